// File: rtl/spi_vec_loader.sv
// SPI-slave frame loader: streams NUM_WORDS x WORD_W bits into a shadow buffer, published on load_if_ready.
// Optional MISO readback of the live vectors is enabled by defining SPI_MISO_READBACK_EN.
module spi_vec_loader #(
  parameter int                            NUM_WORDS   = 6,
  parameter int                            WORD_W      = 24,
  parameter logic [NUM_WORDS*WORD_W-1:0]   RESET_VALUE = '0,
  parameter bit                            SAMPLE_FALL = 1'b0
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             i_sclk,
  input  logic                             i_ss_n,
  input  logic                             i_mosi,
  input  logic                             load_if_ready,
  output logic [NUM_WORDS*WORD_W-1:0]      o_vectors,
  output logic                             o_ready,
  output logic                             o_loaded,
  output logic                             o_frame_err,
  output logic                             o_miso
);

  localparam int              FB        = NUM_WORDS * WORD_W;
  localparam int              CNT_W     = $clog2(FB);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FB - 1);
  // Idle level of SCLK chosen so that leaving reset never looks like a sample edge.
  localparam logic [2:0]      SCLK_IDLE = SAMPLE_FALL ? 3'b111 : 3'b000;

  logic [2:0]       sclk_sync_reg;
  logic [1:0]       ss_sync_reg;
  logic [1:0]       mosi_sync_reg;
  logic [CNT_W-1:0] bit_cnt_reg;
  logic [FB-1:0]    rx_reg;
  logic [FB-1:0]    shadow_reg;
  logic             frame_done_reg;

  logic sclk_rise, sclk_fall, sample_edge, ss_active, mosi_bit, frame_wrap, short_abort;

  assign sclk_rise   = sclk_sync_reg[1] & ~sclk_sync_reg[2];
  assign sclk_fall   = ~sclk_sync_reg[1] & sclk_sync_reg[2];
  assign sample_edge = SAMPLE_FALL ? sclk_fall : sclk_rise;
  assign ss_active   = ~ss_sync_reg[1];
  assign mosi_bit    = mosi_sync_reg[1];
  assign frame_wrap  = ss_active & sample_edge & (bit_cnt_reg == CNT_LAST);
  assign short_abort = ~ss_active & (bit_cnt_reg != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sclk_sync_reg <= SCLK_IDLE;
      ss_sync_reg   <= 2'b11;
      mosi_sync_reg <= 2'b00;
    end else begin
      sclk_sync_reg <= {sclk_sync_reg[1:0], i_sclk};
      ss_sync_reg   <= {ss_sync_reg[0], i_ss_n};
      mosi_sync_reg <= {mosi_sync_reg[0], i_mosi};
    end
  end

  // Receive side: partial frames are never copied out, so a restart simply overwrites rx_reg.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_cnt_reg    <= '0;
      rx_reg         <= '0;
      frame_done_reg <= 1'b0;
    end else begin
      frame_done_reg <= frame_wrap;
      if (!ss_active) begin
        bit_cnt_reg <= '0;
      end else if (sample_edge) begin
        rx_reg <= {rx_reg[FB-2:0], mosi_bit};
        if (bit_cnt_reg == CNT_LAST) begin
          bit_cnt_reg <= '0;
        end else begin
          bit_cnt_reg <= bit_cnt_reg + 1'b1;
        end
      end
    end
  end

  // A load on the same edge as a shadow update publishes the old shadow and keeps o_ready set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow_reg  <= '0;
      o_vectors   <= RESET_VALUE;
      o_ready     <= 1'b0;
      o_loaded    <= 1'b0;
      o_frame_err <= 1'b0;
    end else begin
      o_loaded <= 1'b0;
      if (load_if_ready && o_ready) begin
        o_vectors <= shadow_reg;
        o_loaded  <= 1'b1;
        o_ready   <= 1'b0;
      end
      if (frame_done_reg) begin
        shadow_reg <= rx_reg;
        o_ready    <= 1'b1;
      end
      if (frame_done_reg) begin
        o_frame_err <= 1'b0;
      end else if (short_abort) begin
        o_frame_err <= 1'b1;
      end
    end
  end

`ifdef SPI_MISO_READBACK_EN
  logic [FB-1:0] tx_reg;
  logic          ss_active_d_reg;
  logic          shift_edge;

  assign shift_edge = SAMPLE_FALL ? sclk_rise : sclk_fall;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_reg          <= '0;
      ss_active_d_reg <= 1'b0;
    end else begin
      ss_active_d_reg <= ss_active;
      if ((ss_active && !ss_active_d_reg) || frame_wrap) begin
        tx_reg <= o_vectors;
      end else if (ss_active && shift_edge) begin
        tx_reg <= {tx_reg[FB-2:0], 1'b0};
      end
    end
  end

  assign o_miso = tx_reg[FB-1];
`else
  assign o_miso = 1'b0;
`endif

endmodule

// File: tb/tb_spi_vec_loader.sv
// Bench for spi_vec_loader: directed table, hand-written corner sequences, random ops against a frame-level model.
module tb_spi_vec_loader;

  localparam logic [15:0] RV_B = 16'hA5C3;

  typedef enum int {OP_LOAD, OP_FRAME, OP_FRAME2, OP_SHORT} op_e;
  typedef struct {
    op_e            op;
    logic [143:0]   d;
    logic [143:0]   d2;
    int             n;
    bit             lat;
    logic           exp_ready;
    logic           exp_err;
    logic           exp_loaded;
    logic [143:0]   exp_vec;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset;
  logic         sclk_a, ss_a, mosi_a, load_a;
  logic [143:0] vec_a;
  logic         ready_a, loaded_a, err_a, miso_a;
  logic         sclk_b, ss_b, mosi_b, load_b;
  logic [15:0]  vec_b;
  logic         ready_b, loaded_b, err_b, miso_b;

  spi_vec_loader #(.NUM_WORDS(6), .WORD_W(24), .RESET_VALUE(144'h0), .SAMPLE_FALL(1'b0)) dut_a (
    .clk(clk), .reset(reset), .i_sclk(sclk_a), .i_ss_n(ss_a), .i_mosi(mosi_a),
    .load_if_ready(load_a), .o_vectors(vec_a), .o_ready(ready_a), .o_loaded(loaded_a),
    .o_frame_err(err_a), .o_miso(miso_a));

  spi_vec_loader #(.NUM_WORDS(2), .WORD_W(8), .RESET_VALUE(RV_B), .SAMPLE_FALL(1'b1)) dut_b (
    .clk(clk), .reset(reset), .i_sclk(sclk_b), .i_ss_n(ss_b), .i_mosi(mosi_b),
    .load_if_ready(load_b), .o_vectors(vec_b), .o_ready(ready_b), .o_loaded(loaded_b),
    .o_frame_err(err_b), .o_miso(miso_b));

  int checks = 0;
  int errors = 0;

  // Frame-level reference state for dut_a.
  logic [143:0] m_live, m_shadow;
  logic         m_ready, m_err;

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chkv(input string name, input logic [143:0] act, input logic [143:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [143:0] rand144();
    logic [159:0] t;
    t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    return t[143:0];
  endfunction

  task automatic hp();
    repeat (4) @(negedge clk);
  endtask

  task automatic ss_set_a(input logic v);
    ss_a = v;
    hp();
  endtask

  // Mode 0 master: MOSI set while SCLK low, sampled on the rising edge.
  task automatic bits_a(input logic [143:0] d, input int n, input bit chk_lat, input bit sim_load);
    for (int i = 0; i < n; i++) begin
      mosi_a = d[143-i];
      hp();
      sclk_a = 1'b1;
      if (i == n - 1 && (chk_lat || sim_load)) begin
        for (int k = 1; k <= 4; k++) begin
          @(negedge clk);
          if (k == 3 && sim_load) load_a = 1'b1;
          if (k == 3 && chk_lat) chk1("latency_ready_at_3clk", ready_a, 1'b0);
          if (k == 4 && sim_load) load_a = 1'b0;
          if (k == 4 && chk_lat) chk1("latency_ready_at_4clk", ready_a, 1'b1);
        end
      end else begin
        hp();
      end
      sclk_a = 1'b0;
    end
  endtask

  task automatic do_op(input op_e op, input logic [143:0] d, input logic [143:0] d2,
                       input int n, input bit lat, output logic lp);
    lp = 1'b0;
    case (op)
      OP_LOAD: begin
        load_a = 1'b1;
        @(negedge clk);
        load_a = 1'b0;
        lp = loaded_a;
        @(negedge clk);
        chk1("loaded_one_cycle", loaded_a, 1'b0);
        if (m_ready) begin
          m_live  = m_shadow;
          m_ready = 1'b0;
        end
      end
      OP_FRAME: begin
        ss_set_a(1'b0); bits_a(d, 144, lat, 1'b0); ss_set_a(1'b1);
        m_shadow = d; m_ready = 1'b1; m_err = 1'b0;
      end
      OP_FRAME2: begin
        ss_set_a(1'b0); bits_a(d, 144, 1'b0, 1'b0); bits_a(d2, 144, 1'b0, 1'b0); ss_set_a(1'b1);
        m_shadow = d2; m_ready = 1'b1; m_err = 1'b0;
      end
      default: begin
        ss_set_a(1'b0); bits_a(d, n, 1'b0, 1'b0); ss_set_a(1'b1);
        m_err = 1'b1;
      end
    endcase
    $display("txn op=%s n=%0d ready=%b err=%b loaded=%b vec=%h", op.name(), n, ready_a, err_a, lp, vec_a);
  endtask

  task automatic chk_model(input string tag);
    chkv({tag, "_vectors"}, vec_a, m_live);
    chk1({tag, "_ready"}, ready_a, m_ready);
    chk1({tag, "_err"}, err_a, m_err);
  endtask

  // Mode with SAMPLE_FALL=1, SCLK idling high; MISO read just before each sample edge.
  task automatic bits_b(input logic [15:0] d, output logic [15:0] rd);
    rd = '0;
    for (int i = 0; i < 16; i++) begin
      mosi_b = d[15-i];
      hp();
      rd[15-i] = miso_b;
      sclk_b = 1'b0;
      hp();
      sclk_b = 1'b1;
    end
  endtask

  task automatic load_b_pulse(output logic lp);
    load_b = 1'b1;
    @(negedge clk);
    load_b = 1'b0;
    lp = loaded_b;
    @(negedge clk);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[12];
    logic [143:0] f1, fa, fb, fc, fd, fe, fx;
    logic [15:0]  rd;
    logic lp;
    bit   seen;
    logic exp_lp;
    int   r;
    int   n;

    f1 = {24'd1, 24'd2, 24'd3, 24'd4, 24'd5, 24'd6};
    fa = {6{24'hABCDEF}};
    fb = {6{24'h13579B}};
    fc = {24'h111111, 24'h222222, 24'h333333, 24'h444444, 24'h555555, 24'h666666};
    fd = {6{24'h0F1E2D}};
    fe = {3{48'hDEADBEEFCAFE}};
    fx = {12{12'hF0F}};

    tbl[0]  = '{OP_LOAD,   '0, '0, 0,   1'b0, 1'b0, 1'b0, 1'b0, '0};
    tbl[1]  = '{OP_FRAME,  f1, '0, 144, 1'b1, 1'b1, 1'b0, 1'b0, '0};
    tbl[2]  = '{OP_LOAD,   '0, '0, 0,   1'b0, 1'b0, 1'b0, 1'b1, f1};
    tbl[3]  = '{OP_SHORT,  fx, '0, 100, 1'b0, 1'b0, 1'b1, 1'b0, f1};
    tbl[4]  = '{OP_LOAD,   '0, '0, 0,   1'b0, 1'b0, 1'b1, 1'b0, f1};
    tbl[5]  = '{OP_FRAME,  fc, '0, 144, 1'b0, 1'b1, 1'b0, 1'b0, f1};
    tbl[6]  = '{OP_LOAD,   '0, '0, 0,   1'b0, 1'b0, 1'b0, 1'b1, fc};
    tbl[7]  = '{OP_FRAME2, fa, fb, 144, 1'b0, 1'b1, 1'b0, 1'b0, fc};
    tbl[8]  = '{OP_LOAD,   '0, '0, 0,   1'b0, 1'b0, 1'b0, 1'b1, fb};
    tbl[9]  = '{OP_FRAME,  fe, '0, 144, 1'b0, 1'b1, 1'b0, 1'b0, fb};
    tbl[10] = '{OP_SHORT,  fx, '0, 50,  1'b0, 1'b1, 1'b1, 1'b0, fb};
    tbl[11] = '{OP_LOAD,   '0, '0, 0,   1'b0, 1'b0, 1'b1, 1'b1, fe};

    reset = 1'b1;
    sclk_a = 1'b0; ss_a = 1'b1; mosi_a = 1'b0; load_a = 1'b0;
    sclk_b = 1'b1; ss_b = 1'b1; mosi_b = 1'b0; load_b = 1'b0;
    m_live = '0; m_shadow = '0; m_ready = 1'b0; m_err = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    chkv("reset_vectors", vec_a, 144'h0);
    chk1("reset_ready", ready_a, 1'b0);
    chk1("reset_err", err_a, 1'b0);
    chk1("reset_miso", miso_a, 1'b0);
    chkv("reset_vectors_b", 144'(vec_b), 144'(RV_B));

    // Holding load with nothing pending must never pulse o_loaded.
    seen = 1'b0;
    load_a = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (loaded_a) seen = 1'b1;
    end
    load_a = 1'b0;
    chk1("no_load_without_ready", seen, 1'b0);

    for (int i = 0; i < 12; i++) begin
      do_op(tbl[i].op, tbl[i].d, tbl[i].d2, tbl[i].n, tbl[i].lat, lp);
      if (tbl[i].op == OP_LOAD) chk1($sformatf("tbl%0d_loaded", i), lp, tbl[i].exp_loaded);
      chkv($sformatf("tbl%0d_vectors", i), vec_a, tbl[i].exp_vec);
      chk1($sformatf("tbl%0d_ready", i), ready_a, tbl[i].exp_ready);
      chk1($sformatf("tbl%0d_err", i), err_a, tbl[i].exp_err);
    end

    // Load coinciding with a shadow update: old shadow goes live, new frame stays pending.
    do_op(OP_FRAME, fc, '0, 144, 1'b0, lp);
    ss_set_a(1'b0);
    bits_a(fd, 144, 1'b0, 1'b1);
    chkv("simul_vectors", vec_a, fc);
    chk1("simul_ready", ready_a, 1'b1);
    chk1("simul_loaded", loaded_a, 1'b1);
    ss_set_a(1'b1);
    m_live = fc; m_shadow = fd; m_ready = 1'b1; m_err = 1'b0;
    $display("txn op=SIMUL_LOAD ready=%b vec=%h", ready_a, vec_a);
    do_op(OP_LOAD, '0, '0, 0, 1'b0, lp);
    chk1("simul_next_loaded", lp, 1'b1);
    chkv("simul_next_vectors", vec_a, fd);

    // Reset partway through a frame, with a frame pending and non-zero live vectors.
    do_op(OP_FRAME, fa, '0, 144, 1'b0, lp);
    ss_set_a(1'b0);
    bits_a(fc, 50, 1'b0, 1'b0);
    reset = 1'b1;
    #1;
    chkv("midreset_vectors", vec_a, 144'h0);
    chk1("midreset_ready", ready_a, 1'b0);
    chk1("midreset_loaded", loaded_a, 1'b0);
    chk1("midreset_err", err_a, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    m_live = '0; m_shadow = '0; m_ready = 1'b0; m_err = 1'b0;
    hp();
    ss_set_a(1'b1);
    $display("txn op=MID_RESET ready=%b err=%b vec=%h", ready_a, err_a, vec_a);
    chk_model("after_reset");
    do_op(OP_FRAME, fe, '0, 144, 1'b0, lp);
    do_op(OP_LOAD, '0, '0, 0, 1'b0, lp);
    chk_model("restart");

    // Random operations checked against the frame-level model.
    for (int it = 0; it < 10; it++) begin
      r = int'($urandom_range(0, 2));
      exp_lp = m_ready;
      if (r == 0) begin
        do_op(OP_FRAME, rand144(), '0, 144, 1'b0, lp);
      end else if (r == 1) begin
        n = int'($urandom_range(1, 143));
        do_op(OP_SHORT, rand144(), '0, n, 1'b0, lp);
      end else begin
        do_op(OP_LOAD, '0, '0, 0, 1'b0, lp);
        chk1($sformatf("rand%0d_loaded", it), lp, exp_lp);
      end
      chk_model($sformatf("rand%0d", it));
    end

    // Small falling-edge instance with MISO readback of the previous live vectors.
    chkv("b_reset_vectors", 144'(vec_b), 144'(RV_B));
    ss_b = 1'b0; hp();
    bits_b(16'h3C96, rd);
    hp(); ss_b = 1'b1; hp();
`ifdef SPI_MISO_READBACK_EN
    chkv("b_miso_frame1", 144'(rd), 144'(RV_B));
`else
    chkv("b_miso_frame1", 144'(rd), 144'h0);
`endif
    chk1("b_ready1", ready_b, 1'b1);
    chk1("b_err1", err_b, 1'b0);
    load_b_pulse(lp);
    chk1("b_loaded1", lp, 1'b1);
    chkv("b_vectors1", 144'(vec_b), 144'(16'h3C96));
    $display("txn dut_b frame=3c96 miso=%h vec=%h", rd, vec_b);
    ss_b = 1'b0; hp();
    bits_b(16'h7E81, rd);
    hp(); ss_b = 1'b1; hp();
`ifdef SPI_MISO_READBACK_EN
    chkv("b_miso_frame2", 144'(rd), 144'(16'h3C96));
`else
    chkv("b_miso_frame2", 144'(rd), 144'h0);
`endif
    load_b_pulse(lp);
    chk1("b_loaded2", lp, 1'b1);
    chkv("b_vectors2", 144'(vec_b), 144'(16'h7E81));
    chk1("b_ready2", ready_b, 1'b0);
    $display("txn dut_b frame=7e81 miso=%h vec=%h", rd, vec_b);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
